sw_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single 7-segment index display between 8 switch requesters.
- Replaces the static lowest-index priority encoding with time-sliced fair grants.
- Each active requester holds the display for DWELL cycles, then the grant rotates to the next active requester.
- Sits between the board switch inputs and the existing seg decoder, which it instantiates on its grant index.

---
 rtl/sw_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 33 +++
 rtl/seg_decoder.sv | 39 +++
 rtl/sw_rr_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sw_rr_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sw_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : sw_arb_pkg
// Purpose  : Shared types and constants for the switch round-robin arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sw_arb_pkg;

  // Requester count is tied to the 3-bit index shown on the display
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//------------------------------------------------------------------------------
// Module   : rr_pick
// Purpose  : Combinational circular search: first set bit of mask at or after
//            start, wrapping modulo N_REQ, plus a found flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import sw_arb_pkg::*;
(
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the farthest offset back to the nearest so the closest hit wins;
  // the 3-bit sum wraps naturally past index 7
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (mask[start + IDX_W'(k)]) begin
        idx   = start + IDX_W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_decoder.sv
//------------------------------------------------------------------------------
// Module   : seg_decoder
// Purpose  : Hex digit to 7-segment decoder, active-high, bit order gfedcba.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Plain lookup of the segment pattern for each hex digit
  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sw_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : sw_rr_arbiter
// Purpose  : Time-sliced round-robin arbiter sharing the 7-segment index
//            display between 8 switch requesters. Each grant is held for DWELL
//            cycles, or until its request or the enable drops.
// Options  : ARB_FIXED_PRIO_EN - adds input fixed_prio; when set, every pick
//            starts at index 0 (lowest index wins).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sw_rr_arbiter
  import sw_arb_pkg::*;
#(
  parameter int DWELL = 50000000,
  parameter int CNT_W = $clog2(DWELL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
`ifdef ARB_FIXED_PRIO_EN
  input  logic             fixed_prio,
`endif
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_oh,
  output logic             gnt_chg,
  output logic [6:0]       seg0
);

  logic [N_REQ-1:0] req_meta_q, req_s_q;
  logic             en_meta_q, en_s_q;
  logic             fixed_prio_s;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic             gnt_chg_q, gnt_chg_d;

  logic [IDX_W-1:0] pick_start;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             end_evt;

  // Two-flop synchronisers for the asynchronous switch inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta_q <= '0;
      req_s_q    <= '0;
      en_meta_q  <= 1'b0;
      en_s_q     <= 1'b0;
    end else begin
      req_meta_q <= req;
      req_s_q    <= req_meta_q;
      en_meta_q  <= en;
      en_s_q     <= en_meta_q;
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  logic fixed_prio_meta_q, fixed_prio_s_q;

  // Priority-mode switch is synchronised exactly like the enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fixed_prio_meta_q <= 1'b0;
      fixed_prio_s_q    <= 1'b0;
    end else begin
      fixed_prio_meta_q <= fixed_prio;
      fixed_prio_s_q    <= fixed_prio_meta_q;
    end
  end

  assign fixed_prio_s = fixed_prio_s_q;
`else
  assign fixed_prio_s = 1'b0;
`endif

  // Search start: saved pointer when idle, just past the holder when granting
  always_comb begin
    pick_start = (state_q == GRANT) ? gnt_idx_q + 1'b1 : ptr_q;
    if (fixed_prio_s) begin
      pick_start = '0;
    end
  end

  rr_pick u_pick (
    .mask  (req_s_q),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign end_evt = (cnt_q == '0) || !req_s_q[gnt_idx_q];

  // Next-state and next-output computation for the grant FSM
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_vld_d = gnt_vld_q;
    gnt_idx_d = gnt_idx_q;
    gnt_chg_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_s_q && (req_s_q != '0) && pick_found) begin
          state_d   = GRANT;
          gnt_idx_d = pick_idx;
          gnt_vld_d = 1'b1;
          cnt_d     = CNT_W'(DWELL - 1);
          gnt_chg_d = 1'b1;
        end
      end
      GRANT: begin
        cnt_d = cnt_q - 1'b1;
        if (!en_s_q) begin
          // Enable loss wins over any simultaneous expiry; pointer is kept
          state_d   = IDLE;
          gnt_vld_d = 1'b0;
          cnt_d     = '0;
        end else if (end_evt) begin
          ptr_d = gnt_idx_q + 1'b1;
          if (pick_found) begin
            gnt_idx_d = pick_idx;
            cnt_d     = CNT_W'(DWELL - 1);
            gnt_chg_d = 1'b1;
          end else begin
            state_d   = IDLE;
            gnt_vld_d = 1'b0;
            cnt_d     = '0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_vld_d = 1'b0;
      end
    endcase
    gnt_oh_d = gnt_vld_d ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx_d) : '0;
  end

  // Grant FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      gnt_chg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_oh_q  <= gnt_oh_d;
      gnt_chg_q <= gnt_chg_d;
    end
  end

  assign gnt_vld = gnt_vld_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_oh  = gnt_oh_q;
  assign gnt_chg = gnt_chg_q;

  seg_decoder u_seg (
    .hex ({1'b0, gnt_idx_q}),
    .seg (seg0)
  );

endmodule

`default_nettype wire

// File: tb/tb_sw_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_sw_rr_arbiter
// Purpose  : Self-checking bench for sw_rr_arbiter with a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sw_rr_arbiter;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       en  = 1'b0;
  logic       fixed_prio = 1'b0;
  logic       gnt_vld;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_oh;
  logic       gnt_chg;
  logic [6:0] seg0;
  logic [19:0] dut_vec;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sw_rr_arbiter #(.DWELL(DWELL)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .en         (en),
`ifdef ARB_FIXED_PRIO_EN
    .fixed_prio (fixed_prio),
`endif
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx),
    .gnt_oh     (gnt_oh),
    .gnt_chg    (gnt_chg),
    .seg0       (seg0)
  );

  assign dut_vec = {gnt_vld, gnt_idx, gnt_oh, gnt_chg, seg0};

  // ---------------- behavioural reference model ----------------
  logic [6:0] seg_tab [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
  logic [7:0] m_req_p1, m_req_s;
  bit   m_en_p1, m_en_s, m_fp_p1, m_fp_s;
  bit   m_busy, m_chg;
  int   m_ptr, m_idx, m_left;

  function automatic int circ_first(logic [7:0] m, int s);
    for (int k = 0; k < 8; k++) begin
      if (m[(s + k) % 8]) return (s + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int j;
    if (rst) begin
      m_req_p1 = 0; m_req_s = 0; m_en_p1 = 0; m_en_s = 0; m_fp_p1 = 0; m_fp_s = 0;
      m_busy = 0; m_chg = 0; m_ptr = 0; m_idx = 0; m_left = 0;
    end else begin
      m_chg = 0;
      if (!m_busy) begin
        if (m_en_s && m_req_s != 0) begin
          m_idx = circ_first(m_req_s, m_fp_s ? 0 : m_ptr);
          m_busy = 1; m_left = DWELL; m_chg = 1;
        end
      end else begin
        m_left = m_left - 1;
        if (!m_en_s) begin
          m_busy = 0;
        end else if (m_left == 0 || !m_req_s[m_idx]) begin
          m_ptr = (m_idx + 1) % 8;
          j = circ_first(m_req_s, m_fp_s ? 0 : m_ptr);
          if (j >= 0) begin
            m_idx = j; m_left = DWELL; m_chg = 1;
          end else begin
            m_busy = 0;
          end
        end
      end
      m_req_s = m_req_p1; m_req_p1 = req;
      m_en_s  = m_en_p1;  m_en_p1  = en;
      m_fp_s  = m_fp_p1;  m_fp_p1  = fixed_prio;
    end
  end

  function automatic logic [19:0] exp_vec();
    logic [7:0] oh;
    oh = m_busy ? (8'h01 << m_idx) : 8'h00;
    return {m_busy, 3'(m_idx), oh, m_chg, seg_tab[m_idx]};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if (dut_vec !== {1'b0, 3'd0, 8'h00, 1'b0, 7'h3F})
      $display("FAIL reset_state: got %h required %h", dut_vec, {1'b0, 3'd0, 8'h00, 1'b0, 7'h3F});
    else n_pass++;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk); n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL model_reset: got %h required %h", dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_alternate();
    int seq[$];
    int at[$];
    int exp_seq[4] = '{0, 2, 0, 2};
    int i;
    en = 1'b1; req = 8'b0000_0101;
    for (i = 0; i < 10 && !gnt_chg; i++) begin
      @(negedge clk); n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL model_alt_start: got %h required %h", dut_vec, exp_vec());
      else n_pass++;
    end
    for (int c = 0; c < 16; c++) begin
      if (gnt_chg) begin seq.push_back(int'(gnt_idx)); at.push_back(c); end
      n_chk++;
      if (gnt_vld !== 1'b1) $display("FAIL alt_no_gap: cycle %0d gnt_vld=%b required 1", c, gnt_vld);
      else n_pass++;
      @(negedge clk); n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL model_alt: got %h required %h", dut_vec, exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (seq.size() < 4 || seq[0] != exp_seq[0] || seq[1] != exp_seq[1] || seq[2] != exp_seq[2]
        || seq[3] != exp_seq[3] || at[1] != 4 || at[2] != 8 || at[3] != 12)
      $display("FAIL alt_sequence: got %0d grants first %p at %p, required 0,2,0,2 at 0,4,8,12", seq.size(), seq, at);
    else n_pass++;
  endtask

  task automatic test_single();
    int i, nchg;
    req = 8'b1000_0000;
    for (i = 0; i < 20 && !(gnt_chg && gnt_idx == 3'd7); i++) begin
      @(negedge clk); n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL model_single_start: got %h required %h", dut_vec, exp_vec());
      else n_pass++;
    end
    nchg = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (gnt_chg) nchg++;
      n_chk++;
      if (gnt_idx !== 3'd7 || gnt_vld !== 1'b1) $display("FAIL single_hold: idx=%0d vld=%b required 7/1", gnt_idx, gnt_vld);
      else n_pass++;
    end
    n_chk++;
    if (nchg != 3) $display("FAIL single_regrant: %0d pulses required 3", nchg);
    else n_pass++;
    req = 8'h00;
    repeat (8) begin
      @(negedge clk); n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL model_single_end: got %h required %h", dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_drop_midway();
    int i;
    req = 8'b0000_0100;
    for (i = 0; i < 10 && !gnt_chg; i++) @(negedge clk);
    n_chk++;
    if (gnt_idx !== 3'd2 || gnt_chg !== 1'b1) $display("FAIL drop_first_grant: idx=%0d chg=%b required 2/1", gnt_idx, gnt_chg);
    else n_pass++;
    req = 8'b0010_0000;
    repeat (3) @(negedge clk);
    n_chk++;
    if (gnt_idx !== 3'd5 || gnt_chg !== 1'b1 || gnt_oh !== 8'h20)
      $display("FAIL drop_switch: idx=%0d chg=%b oh=%h required 5/1/20", gnt_idx, gnt_chg, gnt_oh);
    else n_pass++;
    repeat (4) begin
      @(negedge clk); n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL model_drop: got %h required %h", dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_en_drop();
    int i;
    req = 8'b0001_0000;
    for (i = 0; i < 20 && !(gnt_chg && gnt_idx == 3'd4); i++) @(negedge clk);
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt_chg) break;
    end
    n_chk++;
    if (gnt_idx !== 3'd4 || gnt_chg !== 1'b1) $display("FAIL en_regrant4: idx=%0d chg=%b required 4/1", gnt_idx, gnt_chg);
    else n_pass++;
    en = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (gnt_vld !== 1'b0 || gnt_oh !== 8'h00 || gnt_idx !== 3'd4)
      $display("FAIL en_drop: vld=%b oh=%h idx=%0d required 0/00/4", gnt_vld, gnt_oh, gnt_idx);
    else n_pass++;
    req = 8'b0001_0010; en = 1'b1;
    for (i = 0; i < 10 && !gnt_vld; i++) begin
      @(negedge clk); n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL model_en: got %h required %h", dut_vec, exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (gnt_idx !== 3'd1 || gnt_vld !== 1'b1) $display("FAIL en_wrap: idx=%0d vld=%b required 1/1", gnt_idx, gnt_vld);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int i;
    req = 8'b0100_0000;
    for (i = 0; i < 20 && !(gnt_vld && gnt_idx == 3'd6); i++) @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (dut_vec !== {1'b0, 3'd0, 8'h00, 1'b0, 7'h3F})
      $display("FAIL async_reset: got %h required %h", dut_vec, {1'b0, 3'd0, 8'h00, 1'b0, 7'h3F});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; req = 8'b0000_1000;
    repeat (2) @(negedge clk);
    n_chk++;
    if (gnt_vld !== 1'b0) $display("FAIL reset_latency_early: vld=%b required 0", gnt_vld);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 3'd3 || seg0 !== 7'h4F)
      $display("FAIL reset_latency: vld=%b idx=%0d seg=%h required 1/3/4F", gnt_vld, gnt_idx, seg0);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 5) == 0) req = 8'h00;
      en = ($urandom_range(0, 19) != 0);
`ifdef ARB_FIXED_PRIO_EN
      if ($urandom_range(0, 30) == 0) fixed_prio = ~fixed_prio;
`endif
      @(negedge clk); n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL model_random c%0d: got %h required %h", c, dut_vec, exp_vec());
      else n_pass++;
    end
    fixed_prio = 1'b0;
  endtask

`ifdef ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int prev;
    en = 1'b1; req = 8'h00;
    repeat (6) @(negedge clk);
    fixed_prio = 1'b1; req = 8'b0000_0110;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt_vld) begin
        n_chk++;
        if (gnt_idx !== 3'd1) $display("FAIL fixed_prio_hold: idx=%0d required 1", gnt_idx);
        else n_pass++;
      end
    end
    fixed_prio = 1'b0;
    prev = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (gnt_chg && c > 4) begin
        n_chk++;
        if (int'(gnt_idx) == prev) $display("FAIL rr_alternate: idx=%0d repeated", gnt_idx);
        else n_pass++;
        prev = int'(gnt_idx);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alternate();
    test_single();
    test_drop_midway();
    test_en_drop();
    test_async_reset();
`ifdef ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
